cnt_step_sched: RTL and testbench
=================================

// Module: cnt_step_sched
// PURPOSE
//  Board-level controller for the step-adjustable LED counter. It takes three raw push-buttons
//  and sequences the counter: start/clear, run, pause and an automatic step sweep.
//  It drives the counter's cnt_step input plus enable/clear controls.
//  It sits between the board buttons and the counter datapath in the lab top level.
// PARAMETERS
//  DB_CYCLES     1_000_000   consecutive stable cycles required to accept a button level (10 ms @ 100 MHz)
//  SWEEP_PERIOD  50_000_000  cycles between automatic step increments in SWEEP
//  STEP_W        7           width of cnt_step
// PORTS
//  clk       in   1       system clock, all logic on posedge
//  rst       in   1       synchronous reset, active-high
//  btn_mode  in   1       raw mode button, asynchronous to clk
//  btn_up    in   1       raw step-increment button, asynchronous to clk
//  btn_dn    in   1       raw step-decrement button, asynchronous to clk
//  cnt_step  out  STEP_W  step value fed to the counter, registered
//  cnt_en    out  1       counter advance enable, registered
//  cnt_clr   out  1       one-cycle counter clear pulse, registered
//  state     out  2       current FSM state, for LEDs and debug
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, cnt_step=0, cnt_en=0, cnt_clr=0.
//   Sync FFs, debounced levels, debounce counters and sweep timer all clear to 0.
//   Reset asserted mid-operation takes effect at the next edge and overrides everything.
//  Input path, per button:
//   - 2-FF synchroniser.
//   - Debouncer: the level is accepted after DB_CYCLES consecutive cycles at the new value.
//     Any bounce restarts the count.
//   - A rising edge of the accepted level gives a 1-cycle pulse (p_mode, p_up, p_dn).
//   - Press-to-pulse latency is 2 + DB_CYCLES + 1 cycles.
//   - A button held through reset gives one pulse after that latency, counted from rst release.
//  FSM encoding: IDLE=00, RUN=01, SWEEP=11, PAUSE=10.
//  Event priority, evaluated per cycle in this order:
//   1. p_up & p_dn together (abort): go to IDLE from any state; cnt_step<=0; cnt_clr<=1 for one cycle.
//   2. p_mode transitions:
//      - IDLE->RUN, with cnt_clr<=1 for one cycle.
//      - RUN->SWEEP.
//      - SWEEP->PAUSE.
//      - PAUSE->RUN.
//      Any up/dn pulse in the same cycle is discarded.
//   3. p_up alone in RUN or PAUSE: cnt_step+1, saturating at 2^STEP_W-1.
//      p_dn alone in RUN or PAUSE: cnt_step-1, saturating at 0.
//      Pulses in IDLE or SWEEP are ignored.
//   4. Sweep tick (SWEEP only): sweep timer counts 0..SWEEP_PERIOD-1.
//      At the terminal count, cnt_step<=cnt_step+1 and wraps 127->0 (no saturation).
//      The timer restarts at 0 on every entry to SWEEP and holds at 0 outside SWEEP.
//  cnt_en = 1 in RUN and SWEEP, 0 in IDLE and PAUSE.
//  All outputs are registered; the cycle after a pulse reflects the new state.
//  cnt_clr is high for exactly one cycle per IDLE->RUN or abort.
//  cnt_step is held unchanged across all mode transitions except abort.
// TESTING (bench uses DB_CYCLES=4, SWEEP_PERIOD=8)
//  1. Reset: hold rst 3 cycles with buttons low.
//     -> state=00, cnt_step=0, cnt_en=0, cnt_clr=0; no pulses for 20 cycles.
//  2. Debounce: toggle btn_mode every 2 cycles for 10 cycles, then hold high.
//     -> exactly one state change IDLE->RUN, 7 cycles after the stable hold begins.
//     -> cnt_clr=1 for exactly 1 cycle; cnt_en=1.
//  3. Step saturation: in RUN, 130 clean btn_up presses -> cnt_step=127.
//     Then 2 btn_dn presses -> 125. In PAUSE, btn_dn from 0 -> stays 0, cnt_en=0.
//  4. Sweep wrap: enter SWEEP with cnt_step=126.
//     -> 127 after 8 cycles, 0 after 16; btn_up presses in SWEEP have no effect.
//  5. Simultaneous: in SWEEP, pulse up+dn in the same cycle.
//     -> IDLE, cnt_step=0, cnt_clr 1-cycle pulse. Pulse mode+up together in RUN -> SWEEP, step unchanged.
//  6. Mid-operation reset: assert rst in SWEEP at timer=5.
//     -> next cycle state=00, cnt_step=0, cnt_en=0.
//     -> after re-entering SWEEP, the first tick lands 8 cycles later.

Source files
------------

// File: rtl/cnt_step_sched.sv
// cnt_step_sched: button-driven sequencer for the step-adjustable LED counter.
// Three raw buttons are synchronised, debounced and edge-detected. The resulting
// pulses drive a four-state controller (IDLE/RUN/SWEEP/PAUSE). The controller
// produces the counter's step value, enable and one-cycle clear.
module cnt_step_sched #(
    parameter int DB_CYCLES    = 1_000_000,
    parameter int SWEEP_PERIOD = 50_000_000,
    parameter int STEP_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_dn,
    output logic [STEP_W-1:0] cnt_step,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic [1:0]        state
);

    // Button lane indices inside the packed button vectors
    localparam int B_MODE = 0;
    localparam int B_UP   = 1;
    localparam int B_DN   = 2;

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TM_W = (SWEEP_PERIOD > 1) ? $clog2(SWEEP_PERIOD) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ZERO   = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [TM_W-1:0]   TM_LAST   = TM_W'(SWEEP_PERIOD - 1);
    localparam logic [TM_W-1:0]   TM_ZERO   = {TM_W{1'b0}};
    localparam logic [TM_W-1:0]   TM_ONE    = TM_W'(1);
    localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        SWEEP = 2'b11,
        PAUSE = 2'b10
    } state_t;

    // Input path registers
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db;
    logic [2:0]      r_db_d;
    logic [DB_W-1:0] r_dbcnt [3];
    logic [2:0]      w_btn;
    logic [2:0]      w_pulse;

    // Controller registers and next-state values
    state_t            r_state;
    logic [STEP_W-1:0] r_step;
    logic              r_en;
    logic              r_clr;
    logic [TM_W-1:0]   r_timer;
    state_t            w_state_n;
    logic [STEP_W-1:0] w_step_n;
    logic              w_en_n;
    logic              w_clr_n;
    logic [TM_W-1:0]   w_timer_n;

    assign w_btn   = {btn_dn, btn_up, btn_mode};
    // Rising edge of the accepted level; consumed by the controller on the next edge
    assign w_pulse = r_db & ~r_db_d;

    // Synchronise raw buttons, then accept a level only after DB_CYCLES stable samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_db    <= 3'b000;
            r_db_d  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_dbcnt[i] <= DB_ZERO;
            end
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_dbcnt[i] == DB_LAST) begin
                        r_db[i]    <= r_sync2[i];
                        r_dbcnt[i] <= DB_ZERO;
                    end else begin
                        r_dbcnt[i] <= r_dbcnt[i] + DB_ONE;
                    end
                end else begin
                    // Any sample matching the current level is a bounce: restart
                    r_dbcnt[i] <= DB_ZERO;
                end
            end
        end
    end

    // Controller next-state: abort, then mode, then step buttons, then sweep tick
    always_comb begin
        w_state_n = r_state;
        w_step_n  = r_step;
        w_clr_n   = 1'b0;
        w_timer_n = TM_ZERO;
        if (w_pulse[B_UP] && w_pulse[B_DN]) begin
            w_state_n = IDLE;
            w_step_n  = STEP_ZERO;
            w_clr_n   = 1'b1;
        end else if (w_pulse[B_MODE]) begin
            // Up/down pulses coinciding with a mode pulse are dropped
            case (r_state)
                IDLE: begin
                    w_state_n = RUN;
                    w_clr_n   = 1'b1;
                end
                RUN:     w_state_n = SWEEP;
                SWEEP:   w_state_n = PAUSE;
                PAUSE:   w_state_n = RUN;
                default: w_state_n = IDLE;
            endcase
        end else begin
            case (r_state)
                RUN, PAUSE: begin
                    if (w_pulse[B_UP]) begin
                        if (r_step != STEP_MAX) begin
                            w_step_n = r_step + STEP_ONE;
                        end else begin
                            w_step_n = r_step;
                        end
                    end else if (w_pulse[B_DN]) begin
                        if (r_step != STEP_ZERO) begin
                            w_step_n = r_step - STEP_ONE;
                        end else begin
                            w_step_n = r_step;
                        end
                    end else begin
                        w_step_n = r_step;
                    end
                end
                SWEEP: begin
                    // Sweep step wraps at the top instead of saturating
                    if (r_timer == TM_LAST) begin
                        w_step_n  = r_step + STEP_ONE;
                        w_timer_n = TM_ZERO;
                    end else begin
                        w_timer_n = r_timer + TM_ONE;
                    end
                end
                IDLE:    w_state_n = IDLE;
                default: w_state_n = IDLE;
            endcase
        end
        w_en_n = (w_state_n == RUN) || (w_state_n == SWEEP);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= STEP_ZERO;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
            r_timer <= TM_ZERO;
        end else begin
            r_state <= w_state_n;
            r_step  <= w_step_n;
            r_en    <= w_en_n;
            r_clr   <= w_clr_n;
            r_timer <= w_timer_n;
        end
    end

    assign cnt_step = r_step;
    assign cnt_en   = r_en;
    assign cnt_clr  = r_clr;
    assign state    = r_state;

endmodule

// File: tb/tb_cnt_step_sched.sv
// Bench for cnt_step_sched with short debounce/sweep parameters.
// A behavioural model predicts the outputs after every clock edge. A monitor
// compares the queued predictions against the DUT. Directed phases plus random
// button activity provide the stimulus.
module tb_cnt_step_sched;

    localparam int DB = 4;
    localparam int SP = 8;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_dn;
    logic [6:0] cnt_step;
    logic       cnt_en;
    logic       cnt_clr;
    logic [1:0] state;

    typedef struct packed {
        logic [1:0] st;
        logic [6:0] step;
        logic       en;
        logic       clr;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    cnt_step_sched #(
        .DB_CYCLES    (DB),
        .SWEEP_PERIOD (SP),
        .STEP_W       (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .cnt_step (cnt_step),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: evaluated at each rising edge and queues the expected outputs
    initial begin : model
        logic [1:0] m_state;
        int         m_step;
        int         m_age;
        bit         m_clr;
        bit         m_lvl  [3];
        bit         m_pend [3];
        bit         hist   [3][DB+2];
        logic [2:0] raw;
        bit         unanim;
        exp_t       e;
        m_state = 2'b00; m_step = 0; m_age = 0; m_clr = 1'b0;
        for (int b = 0; b < 3; b++) begin
            m_lvl[b] = 1'b0; m_pend[b] = 1'b0;
            for (int j = 0; j < DB + 2; j++) hist[b][j] = 1'b0;
        end
        forever begin
            @(posedge clk);
            raw = {btn_dn, btn_up, btn_mode};
            if (rst) begin
                m_state = 2'b00; m_step = 0; m_age = 0; m_clr = 1'b0;
                for (int b = 0; b < 3; b++) begin
                    m_lvl[b] = 1'b0; m_pend[b] = 1'b0;
                    for (int j = 0; j < DB + 2; j++) hist[b][j] = 1'b0;
                end
            end else begin
                m_clr = 1'b0;
                if (m_pend[1] && m_pend[2]) begin
                    m_state = 2'b00; m_step = 0; m_clr = 1'b1; m_age = 0;
                end else if (m_pend[0]) begin
                    m_age = 0;
                    case (m_state)
                        2'b00: begin m_state = 2'b01; m_clr = 1'b1; end
                        2'b01: m_state = 2'b11;
                        2'b11: m_state = 2'b10;
                        default: m_state = 2'b01;
                    endcase
                end else if (m_state == 2'b01 || m_state == 2'b10) begin
                    if (m_pend[1]) m_step = (m_step < 127) ? m_step + 1 : 127;
                    else if (m_pend[2]) m_step = (m_step > 0) ? m_step - 1 : 0;
                end else if (m_state == 2'b11) begin
                    m_age++;
                    if (m_age % SP == 0) m_step = (m_step + 1) % 128;
                end
                // Level seen by the debouncer lags the pin by two samples; it is
                // accepted once the last DB such samples agree on a new value
                for (int b = 0; b < 3; b++) begin
                    for (int j = DB + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
                    hist[b][0] = raw[b];
                    unanim = 1'b1;
                    for (int j = 2; j < DB + 2; j++) begin
                        if (hist[b][j] != hist[b][2]) unanim = 1'b0;
                    end
                    m_pend[b] = 1'b0;
                    if (unanim && hist[b][2] != m_lvl[b]) begin
                        m_lvl[b]  = hist[b][2];
                        m_pend[b] = m_lvl[b];
                    end
                end
            end
            e.st   = m_state;
            e.step = 7'(m_step);
            e.en   = (m_state == 2'b01) || (m_state == 2'b11);
            e.clr  = m_clr;
            q.push_back(e);
        end
    end

    // Monitor: pops one prediction per cycle and compares it with the DUT outputs
    initial begin : monitor
        exp_t       e;
        logic [10:0] got;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                got = {state, cnt_step, cnt_en, cnt_clr};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t: got st=%b step=%0d en=%b clr=%b, want st=%b step=%0d en=%b clr=%b",
                             $time, state, cnt_step, cnt_en, cnt_clr, e.st, e.step, e.en, e.clr);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic press(input logic [2:0] m, input int hold, input int gap);
        {btn_dn, btn_up, btn_mode} = m;
        repeat (hold) @(negedge clk);
        {btn_dn, btn_up, btn_mode} = 3'b000;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] st, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state === st) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    // Directed phases followed by random button activity
    initial begin : driver
        int hold;
        rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_step",  32'(cnt_step), 32'd0);
        chk("reset_en",    32'(cnt_en), 32'd0);
        chk("reset_clr",   32'(cnt_clr), 32'd0);
        repeat (20) @(negedge clk);
        chk("idle_quiet", 32'(state), 32'd0);

        // Bouncing mode button, then a stable hold
        for (int i = 0; i < 10; i++) begin
            btn_mode = ((i % 4) < 2);
            @(negedge clk);
        end
        btn_mode = 1'b1;
        repeat (12) @(negedge clk);
        chk("bounce_run_state", 32'(state), 32'd1);
        chk("bounce_run_en",    32'(cnt_en), 32'd1);
        btn_mode = 1'b0;
        repeat (10) @(negedge clk);

        // Saturation at the top, then down steps
        repeat (130) press(3'b010, 8, 8);
        chk("sat_top", 32'(cnt_step), 32'd127);
        repeat (2) press(3'b100, 8, 8);
        chk("after_dn2", 32'(cnt_step), 32'd125);
        press(3'b001, 8, 8);
        press(3'b001, 8, 8);
        chk("pause_state", 32'(state), 32'd2);
        repeat (130) press(3'b100, 8, 8);
        chk("sat_bottom", 32'(cnt_step), 32'd0);
        chk("pause_en",   32'(cnt_en), 32'd0);

        // Sweep wrap starting from 126
        repeat (126) press(3'b010, 8, 8);
        press(3'b001, 8, 8);
        btn_mode = 1'b1;
        wait_state(2'b11, "enter_sweep");
        btn_mode = 1'b0;
        repeat (8) @(negedge clk);
        chk("sweep_tick1", 32'(cnt_step), 32'd127);
        repeat (8) @(negedge clk);
        chk("sweep_wrap", 32'(cnt_step), 32'd0);
        repeat (2) press(3'b010, 8, 8);

        // Abort with up+dn, then mode+up together
        press(3'b110, 8, 8);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_step",  32'(cnt_step), 32'd0);
        press(3'b001, 8, 8);
        repeat (3) press(3'b010, 8, 8);
        press(3'b011, 8, 0);
        chk("mode_up_state", 32'(state), 32'd3);
        chk("mode_up_step",  32'(cnt_step), 32'd3);
        repeat (8) @(negedge clk);

        // Reset in the middle of a sweep period
        press(3'b001, 8, 8);
        press(3'b001, 8, 8);
        btn_mode = 1'b1;
        wait_state(2'b11, "enter_sweep2");
        btn_mode = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_step",  32'(cnt_step), 32'd0);
        chk("midrst_en",    32'(cnt_en), 32'd0);
        press(3'b001, 8, 8);
        press(3'b001, 8, 20);

        // Random button activity with occasional resets
        repeat (200) begin
            {btn_dn, btn_up, btn_mode} = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 12);
            repeat (hold) @(negedge clk);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        {btn_dn, btn_up, btn_mode} = 3'b000;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
